// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: phase-detector FSM encoding, default error width and
// the saturation limit used by the detector and the loop filter.
package adpll_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRefFirst = 2'd1,
    StFbFirst  = 2'd2
  } pd_state_e;

  localparam int unsigned ErrorWidth = 8;

  // Largest magnitude representable symmetrically in a signed value of this width.
  function automatic int unsigned max_count(input int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/adpll_phase_detector_edge_sync.sv
// Synchronizes an asynchronous clock into gen_clk_i and emits a registered
// one-cycle pulse on each rising edge.
module adpll_phase_detector_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic gen_clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/adpll_phase_detector.sv
// Counter-based phase/frequency detector: measures ref/fb rising-edge separation in
// gen_clk_i cycles, publishes a saturated signed error and tracks lock.
module adpll_phase_detector
  import adpll_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH = ErrorWidth,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_TOL    = 2,
  parameter int unsigned LOCK_COUNT  = 16
) (
  input  logic                   gen_clk_i,
  input  logic                   reset_i,
  input  logic                   ref_clk_i,
  input  logic                   fb_clk_i,
  input  logic                   enable_i,
  output logic [ERROR_WIDTH-1:0] error_o,
  output logic                   error_valid_o,
  output logic                   lock_o
);

  localparam int unsigned CntW  = ERROR_WIDTH - 1;
  localparam int unsigned LockW = $clog2(LOCK_COUNT + 1);
  localparam logic [CntW-1:0]  MaxC     = CntW'(max_count(ERROR_WIDTH));
  localparam logic [CntW-1:0]  LockTol  = CntW'(LOCK_TOL);
  localparam logic [LockW-1:0] LockFull = LockW'(LOCK_COUNT);

  logic ref_rise, fb_rise;

  pd_state_e              state_q, state_d;
  logic [CntW-1:0]        count_q, count_d, count_inc;
  logic [ERROR_WIDTH-1:0] error_q, error_d;
  logic                   valid_q, valid_d;
  logic [LockW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   lock_q, lock_d;
  logic                   pub, pub_neg;
  logic [CntW-1:0]        pub_mag;

  adpll_phase_detector_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ref_sync (
    .gen_clk_i(gen_clk_i),
    .reset_i  (reset_i),
    .async_i  (ref_clk_i),
    .rise_o   (ref_rise)
  );

  adpll_phase_detector_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fb_sync (
    .gen_clk_i(gen_clk_i),
    .reset_i  (reset_i),
    .async_i  (fb_clk_i),
    .rise_o   (fb_rise)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    error_d    = error_q;
    valid_d    = 1'b0;
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    pub        = 1'b0;
    pub_neg    = 1'b0;
    pub_mag    = '0;
    count_inc  = (count_q == MaxC) ? MaxC : count_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (ref_rise && fb_rise) begin
          pub = 1'b1;
        end else if (ref_rise) begin
          state_d = StRefFirst;
          count_d = CntW'(1);
        end else if (fb_rise) begin
          state_d = StFbFirst;
          count_d = CntW'(1);
        end
      end
      StRefFirst: begin
        if (ref_rise || fb_rise) begin
          // A lone repeat of the leading edge is a cycle slip: report full scale.
          pub     = 1'b1;
          pub_mag = (ref_rise && !fb_rise) ? MaxC : count_q;
          count_d = CntW'(1);
          if (!ref_rise) begin
            state_d = StIdle;
            count_d = '0;
          end
        end else begin
          count_d = count_inc;
        end
      end
      StFbFirst: begin
        if (ref_rise || fb_rise) begin
          pub     = 1'b1;
          pub_neg = 1'b1;
          pub_mag = (fb_rise && !ref_rise) ? MaxC : count_q;
          count_d = CntW'(1);
          if (!fb_rise) begin
            state_d = StIdle;
            count_d = '0;
          end
        end else begin
          count_d = count_inc;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase

    if (pub) begin
      error_d = pub_neg ? (ERROR_WIDTH'(0) - {1'b0, pub_mag}) : {1'b0, pub_mag};
      valid_d = 1'b1;
      if (pub_mag <= LockTol) begin
        lock_cnt_d = (lock_cnt_q == LockFull) ? LockFull : lock_cnt_q + 1'b1;
        lock_d     = (lock_cnt_d == LockFull);
      end else begin
        lock_cnt_d = '0;
        lock_d     = 1'b0;
      end
    end

    if (!enable_i) begin
      state_d    = StIdle;
      count_d    = '0;
      error_d    = '0;
      valid_d    = 1'b0;
      lock_cnt_d = '0;
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      error_q    <= '0;
      valid_q    <= 1'b0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign error_o       = error_q;
  assign error_valid_o = valid_q;
  assign lock_o        = lock_q;

endmodule

// File: tb/tb_adpll_phase_detector.sv
// Bench for adpll_phase_detector: interval-timestamp reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_adpll_phase_detector;

  localparam int unsigned EW   = 8;
  localparam int unsigned SS   = 2;
  localparam int unsigned LT   = 2;
  localparam int unsigned LC   = 4;
  localparam int          MAXC = 127;

  logic          gen_clk_i = 1'b0;
  logic          reset_i   = 1'b1;
  logic          ref_clk_i = 1'b0;
  logic          fb_clk_i  = 1'b0;
  logic          enable_i  = 1'b1;
  logic [EW-1:0] error_o;
  logic          error_valid_o;
  logic          lock_o;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  adpll_phase_detector #(
    .ERROR_WIDTH(EW),
    .SYNC_STAGES(SS),
    .LOCK_TOL   (LT),
    .LOCK_COUNT (LC)
  ) dut (
    .gen_clk_i    (gen_clk_i),
    .reset_i      (reset_i),
    .ref_clk_i    (ref_clk_i),
    .fb_clk_i     (fb_clk_i),
    .enable_i     (enable_i),
    .error_o      (error_o),
    .error_valid_o(error_valid_o),
    .lock_o       (lock_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  // Reference model: edges become visible to the detector SS+1 cycles after sampling;
  // an open interval is a (kind, start cycle) pair and its error is the elapsed time.
  bit ref_prev, fb_prev, ev_r, ev_f, pub;
  bit ref_pipe[SS+1];
  bit fb_pipe[SS+1];
  int open_kind, open_t, cyc, run, v, exp_err;
  bit exp_valid, exp_lock;

  function automatic int elapsed(input int now, input int start);
    return (now - start > MAXC) ? MAXC : now - start;
  endfunction

  always @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      ref_prev = 0; fb_prev = 0;
      for (int i = 0; i <= SS; i++) begin ref_pipe[i] = 0; fb_pipe[i] = 0; end
      open_kind = 0; open_t = 0; run = 0;
      exp_err = 0; exp_valid = 0; exp_lock = 0;
    end else begin
      cyc++;
      ev_r = ref_pipe[SS];
      ev_f = fb_pipe[SS];
      for (int i = SS; i > 0; i--) begin
        ref_pipe[i] = ref_pipe[i-1];
        fb_pipe[i]  = fb_pipe[i-1];
      end
      ref_pipe[0] = ref_clk_i & ~ref_prev;
      fb_pipe[0]  = fb_clk_i & ~fb_prev;
      ref_prev = ref_clk_i;
      fb_prev  = fb_clk_i;
      exp_valid = 0;
      pub = 0;
      v = 0;
      if (!enable_i) begin
        open_kind = 0; exp_err = 0; run = 0; exp_lock = 0;
      end else begin
        if (ev_r && ev_f) begin
          pub = 1;
          if (open_kind == 1) v = elapsed(cyc, open_t);
          else if (open_kind == 2) v = -elapsed(cyc, open_t);
          open_t = cyc;
        end else if (ev_r) begin
          if (open_kind == 0) begin open_kind = 1; open_t = cyc; end
          else if (open_kind == 1) begin pub = 1; v = MAXC; open_t = cyc; end
          else begin pub = 1; v = -elapsed(cyc, open_t); open_kind = 0; end
        end else if (ev_f) begin
          if (open_kind == 0) begin open_kind = 2; open_t = cyc; end
          else if (open_kind == 2) begin pub = 1; v = -MAXC; open_t = cyc; end
          else begin pub = 1; v = elapsed(cyc, open_t); open_kind = 0; end
        end
        if (pub) begin
          exp_err   = v;
          exp_valid = 1;
          run       = (v <= int'(LT) && v >= -int'(LT)) ? run + 1 : 0;
          exp_lock  = (run >= int'(LC));
        end
      end
    end
  end

  always @(negedge gen_clk_i) begin
    tests++;
    if (error_o !== EW'(exp_err) || error_valid_o !== exp_valid || lock_o !== exp_lock) begin
      fails++;
      $display("FAIL model cyc=%0d err=%0d exp %0d valid=%b exp %b lock=%b exp %b", cyc,
               $signed(error_o), exp_err, error_valid_o, exp_valid, lock_o, exp_lock);
    end
    if (error_valid_o === 1'b1) pulses++;
  end

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  // Raise each input for one cycle, after dref / dfb falling edges (both >= 1).
  task automatic pair(input int dref, input int dfb);
    fork
      begin
        repeat (dref) @(negedge gen_clk_i);
        ref_clk_i = 1'b1;
        @(negedge gen_clk_i);
        ref_clk_i = 1'b0;
      end
      begin
        repeat (dfb) @(negedge gen_clk_i);
        fb_clk_i = 1'b1;
        @(negedge gen_clk_i);
        fb_clk_i = 1'b0;
      end
    join
  endtask

  task automatic wait_pub(input string name, output int val, output int waits);
    val   = 0;
    waits = 0;
    do begin
      @(negedge gen_clk_i);
      waits++;
    end while (error_valid_o !== 1'b1 && waits < 400);
    if (error_valid_o !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s got no strobe expected strobe within 400 cycles", name);
    end else begin
      val = int'($signed(error_o));
    end
  endtask

  int val, w, p0, a, b;

  initial begin
    repeat (3) @(negedge gen_clk_i);
    reset_i = 1'b0;
    repeat (2) @(negedge gen_clk_i);
    #1;
    check("reset_err", int'(error_o), 0);
    check("reset_valid", int'(error_valid_o), 0);
    check("reset_lock", int'(lock_o), 0);

    // ref leads fb by 5
    p0 = pulses;
    pair(1, 6);
    wait_pub("lag5", val, w);
    check("lag5_val", val, 5);
    check("lag5_latency", w + 1, SS + 2);
    repeat (20) @(negedge gen_clk_i);
    #1;
    check("lag5_one_pulse", pulses - p0, 1);

    // fb leads ref by 3
    pair(4, 1);
    wait_pub("lead3", val, w);
    check("lead3_val", val, -3);

    // simultaneous edges
    repeat (5) @(negedge gen_clk_i);
    p0 = pulses;
    pair(1, 1);
    wait_pub("simul", val, w);
    check("simul_val", val, 0);
    repeat (20) @(negedge gen_clk_i);
    #1;
    check("simul_hold", int'($signed(error_o)), 0);
    check("simul_one_pulse", pulses - p0, 1);

    // saturation after a long wait
    pair(1, 201);
    wait_pub("sat", val, w);
    check("sat_val", val, 127);

    // cycle slip: ref, ref 50 later, fb 4 after that
    repeat (5) @(negedge gen_clk_i);
    fork
      pair(1, 55);
      begin
        repeat (51) @(negedge gen_clk_i);
        ref_clk_i = 1'b1;
        @(negedge gen_clk_i);
        ref_clk_i = 1'b0;
      end
      begin
        wait_pub("slip1", val, w);
        check("slip1_val", val, 127);
        wait_pub("slip2", val, w);
        check("slip2_val", val, 4);
      end
    join
    repeat (5) @(negedge gen_clk_i);

    // lock: 1, -2, 0, 1 then 3
    pair(1, 2);
    wait_pub("lk1", val, w);
    check("lk1_val", val, 1);
    check("lk1_lock", int'(lock_o), 0);
    pair(3, 1);
    wait_pub("lk2", val, w);
    check("lk2_val", val, -2);
    check("lk2_lock", int'(lock_o), 0);
    pair(1, 1);
    wait_pub("lk3", val, w);
    check("lk3_val", val, 0);
    check("lk3_lock", int'(lock_o), 0);
    pair(1, 2);
    wait_pub("lk4", val, w);
    check("lk4_val", val, 1);
    check("lk4_lock", int'(lock_o), 1);
    pair(1, 4);
    wait_pub("lk5", val, w);
    check("lk5_val", val, 3);
    check("lk5_lock", int'(lock_o), 0);

    // enable drop inside an open interval
    repeat (5) @(negedge gen_clk_i);
    p0 = pulses;
    fork
      begin
        @(negedge gen_clk_i);
        ref_clk_i = 1'b1;
        @(negedge gen_clk_i);
        ref_clk_i = 1'b0;
      end
      begin
        repeat (7) @(negedge gen_clk_i);
        enable_i = 1'b0;
      end
    join
    repeat (20) @(negedge gen_clk_i);
    #1;
    check("dis_err", int'(error_o), 0);
    check("dis_no_pulse", pulses - p0, 0);
    @(negedge gen_clk_i);
    enable_i = 1'b1;
    pair(1, 7);
    wait_pub("reen", val, w);
    check("reen_val", val, 6);

    // reset in the middle of an interval
    repeat (5) @(negedge gen_clk_i);
    pair(1, 300);
    ref_clk_i = 1'b0;
    @(negedge gen_clk_i);
    ref_clk_i = 1'b1;
    @(negedge gen_clk_i);
    ref_clk_i = 1'b0;
    repeat (8) @(negedge gen_clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_mid_err", int'(error_o), 0);
    check("rst_mid_valid", int'(error_valid_o), 0);
    check("rst_mid_lock", int'(lock_o), 0);
    repeat (3) @(negedge gen_clk_i);
    reset_i = 1'b0;
    p0 = pulses;
    repeat (12) @(negedge gen_clk_i);
    #1;
    check("rst_no_pulse", pulses - p0, 0);
    pair(1, 9);
    wait_pub("post_rst", val, w);
    check("post_rst_val", val, 8);

    // randomized edges and enable toggles, checked by the model
    for (int it = 0; it < 60; it++) begin
      a = int'($urandom_range(1, 60));
      b = int'($urandom_range(1, 60));
      if ($urandom_range(0, 3) == 0) b = a + int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) b = a + int'($urandom_range(130, 160));
      pair(a, b);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge gen_clk_i);
        enable_i = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge gen_clk_i);
        enable_i = 1'b1;
      end
      repeat ($urandom_range(0, 8)) @(negedge gen_clk_i);
    end

    repeat (20) @(negedge gen_clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
